// File: rtl/stopwatch_counter_pkg.sv
// Shared constants for the timekeeping path: FSM state encodings, default
// field limits, adjust-field codes and a small BCD split helper.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJUST = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'b00,
    ADJ_MIN  = 2'b01,
    ADJ_SEC  = 2'b10
  } adj_field_e;

  localparam int SEC_MAX_DEFAULT = 59;
  localparam int MIN_MAX_DEFAULT = 59;

  function automatic logic [3:0] bcd_tens(input int value);
    return 4'((value / 10) % 10);
  endfunction

  function automatic logic [3:0] bcd_ones(input int value);
    return 4'(value % 10);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with a programmable wrap value; wrap is a
// combinational pulse asserted when inc arrives while the count equals max.
module bcd2_counter
  import stopwatch_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [3:0] max_tens,
  input  logic [3:0] max_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    wrap   = 1'b0;
    if (inc) begin
      if (tens_q == max_tens && ones_q == max_ones) begin
        wrap   = 1'b1;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause and per-field adjust; the divider's
// 1 Hz / 2 Hz toggles are sampled as data and edge-detected into ticks.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MIN_MAX = MIN_MAX_DEFAULT,
  parameter int SEC_MAX = SEC_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic [1:0] adj_field
);

  localparam logic [3:0] MIN_MAX_TENS = bcd_tens(MIN_MAX);
  localparam logic [3:0] MIN_MAX_ONES = bcd_ones(MIN_MAX);
  localparam logic [3:0] SEC_MAX_TENS = bcd_tens(SEC_MAX);
  localparam logic [3:0] SEC_MAX_ONES = bcd_ones(SEC_MAX);

  logic       prev_1hz_q, prev_1hz_d;
  logic       prev_2hz_q, prev_2hz_d;
  state_e     state_q, state_d;
  adj_field_e adj_field_q, adj_field_d;

  logic tick1, tick2;
  logic sec_inc, min_inc, sec_wrap, min_wrap;

  assign tick1 = clk_1hz & ~prev_1hz_q;
  assign tick2 = clk_2hz & ~prev_2hz_q;

  // Increments act on the state held before the edge, so a tick coinciding
  // with a transition follows the old state.
  assign sec_inc = (state_q == ST_RUN    && tick1) ||
                   (state_q == ST_ADJUST && tick2 &&  sel);
  assign min_inc = (state_q == ST_RUN    && sec_wrap) ||
                   (state_q == ST_ADJUST && tick2 && !sel);

  always_comb begin
    prev_1hz_d = clk_1hz;
    prev_2hz_d = clk_2hz;
    state_d    = state_q;
    case (state_q)
      ST_RUN: begin
        if (adj)        state_d = ST_ADJUST;
        else if (pause) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (adj)        state_d = ST_ADJUST;
        else if (pause) state_d = ST_RUN;
      end
      ST_ADJUST: begin
        if (!adj)       state_d = ST_PAUSED;
      end
      default:          state_d = ST_RUN;
    endcase
    adj_field_d = ADJ_NONE;
    if (state_d == ST_ADJUST) adj_field_d = sel ? ADJ_SEC : ADJ_MIN;
  end

  // History registers load the live levels during reset too, so a divider
  // output already high at release does not produce a tick.
  always_ff @(posedge clk) begin
    prev_1hz_q <= prev_1hz_d;
    prev_2hz_q <= prev_2hz_d;
    if (rst) begin
      state_q     <= ST_RUN;
      adj_field_q <= ADJ_NONE;
    end else begin
      state_q     <= state_d;
      adj_field_q <= adj_field_d;
    end
  end

  bcd2_counter u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_inc),
    .max_tens (SEC_MAX_TENS),
    .max_ones (SEC_MAX_ONES),
    .tens     (sec_tens),
    .ones     (sec_ones),
    .wrap     (sec_wrap)
  );

  bcd2_counter u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_inc),
    .max_tens (MIN_MAX_TENS),
    .max_ones (MIN_MAX_ONES),
    .tens     (min_tens),
    .ones     (min_ones),
    .wrap     (min_wrap)
  );

  assign running   = (state_q == ST_RUN);
  assign adj_field = adj_field_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: reset, counting and wrap, pause,
// adjust, same-cycle events and reset mid-adjust.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst, clk_1hz, clk_2hz, pause, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running;
  logic [1:0] adj_field;

  int checks   = 0;
  int failures = 0;

  stopwatch_counter dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1hz   (clk_1hz),
    .clk_2hz   (clk_2hz),
    .pause     (pause),
    .adj       (adj),
    .sel       (sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .adj_field (adj_field)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_1hz(input int n);
    repeat (n) begin
      @(negedge clk) clk_1hz = 1'b1;
      cycles(2);
      clk_1hz = 1'b0;
      cycles(1);
    end
  endtask

  task automatic pulse_2hz(input int n);
    repeat (n) begin
      @(negedge clk) clk_2hz = 1'b1;
      cycles(2);
      clk_2hz = 1'b0;
      cycles(1);
    end
  endtask

  task automatic pulse_pause();
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
  endtask

  task automatic set_adj(input logic a, input logic s);
    @(negedge clk) begin adj = a; sel = s; end
    cycles(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_1hz = 1'b1; clk_2hz = 1'b1;
    pause = 1'b0; adj = 1'b0; sel = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(3);
    checks++;
    if (digits() !== 16'h0000) begin
      failures++; $display("FAIL reset_digits got=%h want=0000", digits());
    end
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL reset_running got=%b want=1", running);
    end
    checks++;
    if (adj_field !== 2'b00) begin
      failures++; $display("FAIL reset_adj_field got=%b want=00", adj_field);
    end
    clk_1hz = 1'b0; clk_2hz = 1'b0;
    cycles(2);
  endtask

  task automatic test_count_wrap();
    pulse_1hz(61);
    checks++;
    if (digits() !== 16'h0101) begin
      failures++; $display("FAIL count_61 got=%h want=0101", digits());
    end
    // Preset to 59:59 through adjust mode, then back to RUN.
    set_adj(1'b1, 1'b0);
    pulse_2hz(58);
    sel = 1'b1;
    pulse_2hz(58);
    set_adj(1'b0, 1'b1);
    pulse_pause();
    checks++;
    if (digits() !== 16'h5959 || running !== 1'b1) begin
      failures++; $display("FAIL preset_5959 got=%h run=%b want=5959 run=1", digits(), running);
    end
    pulse_1hz(1);
    checks++;
    if (digits() !== 16'h0000) begin
      failures++; $display("FAIL wrap_5959 got=%h want=0000", digits());
    end
  endtask

  task automatic test_pause();
    pulse_pause();
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL pause_running got=%b want=0", running);
    end
    pulse_1hz(5);
    checks++;
    if (digits() !== 16'h0000) begin
      failures++; $display("FAIL paused_hold got=%h want=0000", digits());
    end
    pulse_pause();
    pulse_1hz(3);
    checks++;
    if (digits() !== 16'h0003 || running !== 1'b1) begin
      failures++; $display("FAIL resume_3 got=%h run=%b want=0003 run=1", digits(), running);
    end
  endtask

  task automatic test_adjust();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h5910; exp_seq[1] = 16'h0010; exp_seq[2] = 16'h0110;
    set_adj(1'b1, 1'b0);
    checks++;
    if (adj_field !== 2'b01 || running !== 1'b0) begin
      failures++; $display("FAIL adj_enter got=%b run=%b want=01 run=0", adj_field, running);
    end
    pulse_2hz(58);
    sel = 1'b1;
    pulse_2hz(7);
    checks++;
    if (adj_field !== 2'b10 || digits() !== 16'h5810) begin
      failures++; $display("FAIL adj_sec got=%h field=%b want=5810 field=10", digits(), adj_field);
    end
    sel = 1'b0;
    cycles(1);
    for (int i = 0; i < 3; i++) begin
      pulse_2hz(1);
      checks++;
      if (digits() !== exp_seq[i]) begin
        failures++; $display("FAIL adj_min_step%0d got=%h want=%h", i, digits(), exp_seq[i]);
      end
    end
    pulse_1hz(2);
    pulse_pause();
    checks++;
    if (digits() !== 16'h0110 || adj_field !== 2'b01) begin
      failures++; $display("FAIL adj_ignore got=%h field=%b want=0110 field=01", digits(), adj_field);
    end
    set_adj(1'b0, 1'b0);
    checks++;
    if (running !== 1'b0 || adj_field !== 2'b00) begin
      failures++; $display("FAIL adj_exit run=%b field=%b want run=0 field=00", running, adj_field);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    pulse_1hz(9);
    @(negedge clk) begin clk_1hz = 1'b1; pause = 1'b1; end
    @(negedge clk) pause = 1'b0;
    checks++;
    if (digits() !== 16'h0010 || running !== 1'b0) begin
      failures++; $display("FAIL tick_pause got=%h run=%b want=0010 run=0", digits(), running);
    end
    clk_1hz = 1'b0;
    cycles(1);
    @(negedge clk) begin adj = 1'b1; pause = 1'b1; end
    @(negedge clk) pause = 1'b0;
    checks++;
    if (adj_field !== 2'b01 || running !== 1'b0) begin
      failures++; $display("FAIL adj_pause field=%b run=%b want field=01 run=0", adj_field, running);
    end
    set_adj(1'b0, 1'b0);
    pulse_pause();
    @(negedge clk) begin adj = 1'b1; clk_2hz = 1'b1; end
    cycles(1);
    checks++;
    if (digits() !== 16'h0010 || adj_field !== 2'b01) begin
      failures++; $display("FAIL tick2_adj_rise got=%h field=%b want=0010 field=01", digits(), adj_field);
    end
    clk_2hz = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset_mid();
    pulse_2hz(12);
    sel = 1'b1;
    pulse_2hz(24);
    checks++;
    if (digits() !== 16'h1234) begin
      failures++; $display("FAIL preset_1234 got=%h want=1234", digits());
    end
    @(negedge clk) begin rst = 1'b1; adj = 1'b0; clk_2hz = 1'b1; end
    @(negedge clk) rst = 1'b0;
    checks++;
    if (digits() !== 16'h0000 || running !== 1'b1 || adj_field !== 2'b00) begin
      failures++; $display("FAIL reset_mid got=%h run=%b field=%b want=0000 run=1 field=00",
                           digits(), running, adj_field);
    end
    clk_2hz = 1'b0;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_pause();
    test_adjust();
    pulse_pause();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core directly downstream of the clock divider. Runs on the 100 MHz system clock.
- Consumes the divider's clk_1hz and clk_2hz toggle outputs as data signals only. Never uses them as clocks.
- Rising-edge-detects each of them to get single-cycle ticks.
- Maintains an MM:SS stopwatch in BCD, with run/pause and a per-field adjust mode.
- Drives the seven-segment display stage, which muxes the digits using clk_fst and blinks the adjusted field using clk_blnk.

Parameters:
- MIN_MAX, 59: highest minutes value before wrap to 00. Legal range 1..99.
- SEC_MAX, 59: highest seconds value before wrap to 00. Legal range 1..99.

Ports:
- clk  input  1  100 MHz system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- clk_1hz  input  1  1 Hz toggle from the divider; sampled as data.
- clk_2hz  input  1  2 Hz toggle from the divider; sampled as data.
- pause  input  1  single-cycle pulse from the debouncer; toggles RUN/PAUSED.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; adjust field select, 0 = minutes, 1 = seconds.
- min_tens  output  4  BCD minutes tens digit.
- min_ones  output  4  BCD minutes ones digit.
- sec_tens  output  4  BCD seconds tens digit.
- sec_ones  output  4  BCD seconds ones digit.
- running  output  1  1 when state == RUN.
- adj_field  output  2  00 = none, 01 = minutes being adjusted, 10 = seconds being adjusted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst. All state changes occur on posedge clk.
- Reset (rst=1 at an edge):
  - All digits become 0.
  - State becomes RUN; running=1; adj_field=00.
  - The edge-detect history registers load the current clk_1hz/clk_2hz levels, so no spurious tick occurs on reset release.
- Edge detection:
  - tick1 = clk_1hz & ~prev_1hz; tick2 = clk_2hz & ~prev_2hz.
  - prev registers update every edge.
  - Each tick is high for exactly one clk cycle per input rising edge.
- FSM states: RUN, PAUSED, ADJUST.
  - RUN -> PAUSED on pause.
  - PAUSED -> RUN on pause.
  - RUN or PAUSED -> ADJUST when adj=1. adj has priority over a same-cycle pause.
  - ADJUST -> PAUSED when adj=0.
  - pause is ignored in ADJUST.
- Counting in RUN, on tick1:
  - seconds += 1; at SEC_MAX, wrap to 00 and minutes += 1.
  - Minutes at MIN_MAX wrap to 00, so 59:59 -> 00:00.
  - No counting in PAUSED or ADJUST.
- Adjust, on tick2:
  - The selected field increments by 1, wrapping at its MAX to 00.
  - No carry into the other field.
  - sel may change at any time and takes effect on the next tick2.
- Latency:
  - A tick detected at edge k updates the digits at edge k; new values are visible after edge k.
  - running and adj_field are registered from state, same edge as the transition.
- Simultaneous events: a tick and a state change in the same cycle act on the state held before the edge.
  - tick1 together with pause while in RUN: count increments and state goes to PAUSED.
  - tick1 together with pause while in PAUSED: no count; state goes to RUN.
  - tick2 together with adj rising: no adjust increment that cycle.
- BCD rules:
  - Each ones digit runs 0..9 and carries into its tens digit.
  - Wrap compares the full two-digit value against MAX.
  - Digits never take values above 9.
- Reset mid-operation: at the next edge all outputs return to their reset values, regardless of state or pending ticks.

Decomposition:
- The shared constants include, also used by the divider, gains:
  - state encodings ST_RUN, ST_PAUSED, ST_ADJUST;
  - default SEC_MAX and MIN_MAX;
  - adj_field codes.
- One sub-module, bcd2_counter: two-digit BCD counter with inputs inc and max_val (tens/ones) and outputs tens, ones, and wrap (a combinational pulse when inc occurs at max).
  - Instantiated twice, for seconds and minutes.
  - The seconds instance's wrap is gated by state to form the minutes inc in RUN.

Test Plan:
- Reset, then release with clk_1hz already high -> no tick; digits 00:00, running=1, adj_field=00.
- RUN, 61 rising edges of clk_1hz -> 01:01. Preset to 59:59, one more edge -> 00:00.
- pause pulse, then 5 clk_1hz edges -> digits unchanged, running=0. Second pause, then 3 edges -> count advances by 3.
- adj=1, sel=0, 3 clk_2hz edges starting at 58:10 -> minutes 58 -> 59 -> 00 -> 01, seconds stay 10, adj_field=01, clk_1hz ignored. adj=0 -> PAUSED.
- Same-cycle pause and tick1 in RUN at 00:09 -> 00:10 and running=0. Same-cycle adj=1 and pause -> ADJUST.
- rst asserted mid-ADJUST at 12:34 -> next edge 00:00, RUN, adj_field=00.
